// File: rtl/filter_capture_if.sv
// Read-side stream of filter_capture: one stored dout/error pair per transfer.
// master = capture buffer (producer), slave = host/readout logic (consumer).
interface filter_capture_if #(
    parameter int WIDTH = 16
);
    logic             rd_valid;
    logic             rd_ready;
    logic [WIDTH-1:0] rd_dout;
    logic [WIDTH-1:0] rd_error;
    logic             rd_last;

    modport master (
        output rd_valid,
        output rd_dout,
        output rd_error,
        output rd_last,
        input  rd_ready
    );

    modport slave (
        input  rd_valid,
        input  rd_dout,
        input  rd_error,
        input  rd_last,
        output rd_ready
    );
endinterface

// File: rtl/filter_capture.sv
// Capture buffer for adaptive_filter dout/error pairs with valid/ready readout.
// Define FILTER_CAPTURE_WRAP_EN for circular capture; default is one-shot.
module filter_capture #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             sample_valid,
    input  logic [WIDTH-1:0] dout_in,
    input  logic [WIDTH-1:0] error_in,
    filter_capture_if.master rd,
    output logic             busy,
    output logic [AW:0]      count,
    output logic             overflow
);
    typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE  = (AW+1)'(1);
    localparam logic [AW:0] NONE = '0;

    state_t             state;
    state_t             state_next;
    logic [2*WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      wr_ptr_next;
    logic [AW-1:0]      rd_ptr;
    logic [AW-1:0]      oldest;
    logic [AW-1:0]      fetch_addr;
    logic [AW:0]        count_cap;
    logic [AW:0]        pending;
    logic [2*WIDTH-1:0] wr_word;
    logic [2*WIDTH-1:0] fetch_word;
    logic               wr_en;
    logic               xfer;
    logic               fetch;
    logic               enter_capture;
    logic               enter_drain;

    assign busy = (state != IDLE);

    // Capture-side bookkeeping as it will look after this edge; the oldest pair is
    // slot 0 unless the buffer is full, in which case it is the next write slot.
    always_comb begin
        wr_en       = (state == CAPTURE) && sample_valid;
        xfer        = rd.rd_valid && rd.rd_ready;
        wr_word     = {dout_in, error_in};
        wr_ptr_next = wr_en ? wr_ptr + 1'b1 : wr_ptr;
        count_cap   = (wr_en && count != FULL) ? count + 1'b1 : count;
        oldest      = (count_cap == FULL) ? wr_ptr_next : '0;
        pending     = count - {{AW{1'b0}}, rd.rd_valid};
    end

    always_comb begin
        state_next    = state;
        enter_capture = 1'b0;
        enter_drain   = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next    = CAPTURE;
                    enter_capture = 1'b1;
                end
            end
            CAPTURE: begin
`ifdef FILTER_CAPTURE_WRAP_EN
                if (stop) begin
                    if (count_cap != NONE) begin
                        state_next  = DRAIN;
                        enter_drain = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
`else
                if ((wr_en && count_cap == FULL) || (stop && count_cap != NONE)) begin
                    state_next  = DRAIN;
                    enter_drain = 1'b1;
                end else if (stop) begin
                    state_next = IDLE;
                end
`endif
            end
            DRAIN: begin
                if (xfer && count == ONE) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Prefetch keeps the output register full while words remain, so a consumer
    // holding rd_ready high sees one word per cycle. The pair written on the edge
    // that enters DRAIN is forwarded straight from the inputs.
    always_comb begin
        fetch_addr = enter_drain ? oldest : rd_ptr;
        fetch      = enter_drain ||
                     ((state == DRAIN) && (!rd.rd_valid || xfer) && pending != NONE);
        fetch_word = (wr_en && wr_ptr == fetch_addr) ? wr_word : mem[fetch_addr];
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_word;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            rd.rd_valid <= 1'b0;
            rd.rd_last  <= 1'b0;
            rd.rd_dout  <= '0;
            rd.rd_error <= '0;
        end else begin
            if (enter_capture) begin
                wr_ptr <= '0;
                count  <= '0;
            end else if (state == CAPTURE) begin
                wr_ptr <= wr_ptr_next;
                count  <= count_cap;
            end else if (xfer) begin
                count <= count - 1'b1;
            end

            if (fetch) begin
                rd.rd_valid                <= 1'b1;
                {rd.rd_dout, rd.rd_error}  <= fetch_word;
                rd.rd_last                 <= enter_drain ? (count_cap == ONE) : (pending == ONE);
                rd_ptr                     <= fetch_addr + 1'b1;
            end else if (xfer) begin
                rd.rd_valid <= 1'b0;
                rd.rd_last  <= 1'b0;
            end
        end
    end

`ifdef FILTER_CAPTURE_WRAP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                         overflow <= 1'b0;
        else if (enter_capture)          overflow <= 1'b0;
        else if (wr_en && count == FULL) overflow <= 1'b1;
    end
`else
    assign overflow = 1'b0;
`endif
endmodule

// File: tb/tb_filter_capture.sv
// Scoreboard bench for filter_capture (DEPTH = 8); expectations follow the
// capture mode selected by FILTER_CAPTURE_WRAP_EN.
module tb_filter_capture;
    localparam int W  = 16;
    localparam int D  = 8;
    localparam int AW = $clog2(D);

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          stop;
    logic          sample_valid;
    logic [W-1:0]  dout_in;
    logic [W-1:0]  error_in;
    logic          busy;
    logic [AW:0]   count;
    logic          overflow;

    filter_capture_if #(.WIDTH(W)) rd_if ();

    filter_capture #(.WIDTH(W), .DEPTH(D)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .stop         (stop),
        .sample_valid (sample_valid),
        .dout_in      (dout_in),
        .error_in     (error_in),
        .rd           (rd_if.master),
        .busy         (busy),
        .count        (count),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    int            compared   = 0;
    int            mismatched = 0;
    logic [2*W-1:0] sb[$];
    bit            model_cap  = 1'b0;
    bit            model_ovf  = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus; the model mirrors what the buffer should hold.
    task automatic step(input bit sv, input logic [W-1:0] d, input logic [W-1:0] e,
                        input bit st, input bit sp);
        sample_valid = sv;
        dout_in      = d;
        error_in     = e;
        start        = st;
        stop         = sp;
        if (st) begin
            sb.delete();
            model_cap = 1'b1;
            model_ovf = 1'b0;
        end else if (sv && model_cap) begin
            if (sb.size() == D) begin
                void'(sb.pop_front());
                model_ovf = 1'b1;
            end
            sb.push_back({d, e});
`ifndef FILTER_CAPTURE_WRAP_EN
            if (sb.size() == D) model_cap = 1'b0;
`endif
        end
        if (sp && !st) model_cap = 1'b0;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        start        = 1'b0;
        stop         = 1'b0;
    endtask

    task automatic drain(input int n, input bit toggle);
        int             done    = 0;
        int             cyc     = 0;
        int             k       = 0;
        bit             stalled = 1'b0;
        bit [3:0]       pat     = 4'b1001;
        logic [2*W-1:0] held;
        logic           held_last;
        logic [2*W-1:0] exp;
        bit             rdy;
        while (done < n && cyc < 200) begin
            check("rd_valid_drain", rd_if.rd_valid, 1);
            check("count_drain", count, sb.size());
            if (stalled) begin
                check("hold_data", {rd_if.rd_dout, rd_if.rd_error}, held);
                check("hold_last", rd_if.rd_last, held_last);
            end
            rdy = toggle ? pat[k % 4] : 1'b1;
            k++;
            rd_if.rd_ready = rdy;
            if (rdy && rd_if.rd_valid && sb.size() > 0) begin
                exp = sb.pop_front();
                check("rd_dout", rd_if.rd_dout, exp[2*W-1:W]);
                check("rd_error", rd_if.rd_error, exp[W-1:0]);
                check("rd_last", rd_if.rd_last, sb.size() == 0);
                done++;
                stalled = 1'b0;
            end else begin
                stalled   = 1'b1;
                held      = {rd_if.rd_dout, rd_if.rd_error};
                held_last = rd_if.rd_last;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        rd_if.rd_ready = 1'b0;
        if (done < n) check("drain_timeout", done, n);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_rd_valid"}, rd_if.rd_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_count"}, count, 0);
    endtask

    initial begin
        rst            = 1'b1;
        start          = 1'b0;
        stop           = 1'b0;
        sample_valid   = 1'b0;
        dout_in        = '0;
        error_in       = '0;
        rd_if.rd_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        $display("[TB] reset values");
        check("rst_rd_valid", rd_if.rd_valid, 0);
        check("rst_rd_last", rd_if.rd_last, 0);
        check("rst_busy", busy, 0);
        check("rst_overflow", overflow, 0);
        check("rst_count", count, 0);
        check("rst_rd_dout", rd_if.rd_dout, 0);
        check("rst_rd_error", rd_if.rd_error, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] five samples, back-to-back readout");
        step(0, 0, 0, 1, 0);
        check("busy_after_start", busy, 1);
        for (int i = 1; i <= 5; i++) step(1, W'(i), W'(16'h0FF + i), 0, 0);
        check("count_captured", count, 5);
        step(0, 0, 0, 0, 1);
        drain(5, 0);
        check_idle("end5");

        $display("[TB] stalled readout with rd_ready 1,0,0,1");
        step(0, 0, 0, 1, 0);
        for (int i = 0; i < 6; i++) step(1, W'(16'h1234 * (i + 1)), W'(16'hF00F ^ i), 0, 0);
        step(0, 0, 0, 0, 1);
        drain(6, 1);
        check_idle("end_toggle");

        $display("[TB] stop with nothing captured");
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1);
        check("empty_stop_busy", busy, 0);
        for (int i = 0; i < 4; i++) begin
            check("empty_stop_rd_valid", rd_if.rd_valid, 0);
            @(posedge clk);
            #1;
        end

        $display("[TB] start and stop together, stop coincident with sample");
        step(0, 0, 0, 1, 1);
        check("start_wins_busy", busy, 1);
        step(1, 16'hAAAA, 16'h5555, 0, 0);
        step(1, 16'hBEEF, 16'hCAFE, 0, 1);
        drain(2, 0);
        check_idle("end_coinc");

        $display("[TB] twelve samples into an eight-deep buffer");
        step(0, 0, 0, 1, 0);
        for (int i = 1; i <= 12; i++) step(1, W'(i), W'(16'h100 + i - 1), 0, 0);
        check("full_count", count, D);
        check("full_overflow", overflow, model_ovf);
        step(0, 0, 0, 0, 1);
        check("full_overflow_drain", overflow, model_ovf);
        drain(D, 0);
        check_idle("end_full");

        $display("[TB] reset during drain");
        step(0, 0, 0, 1, 0);
        for (int i = 0; i < 6; i++) step(1, W'(16'h0200 + i), W'(16'h0300 + i), 0, 0);
        step(0, 0, 0, 0, 1);
        drain(2, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_idle("mid_reset");
        rst = 1'b0;
        sb.delete();
        model_cap = 1'b0;
        step(0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) step(1, W'(16'h00A0 + i), W'(16'h00B0 + i), 0, 0);
        step(0, 0, 0, 0, 1);
        drain(3, 0);
        check_idle("after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
